switch_share_arbiter: RTL and testbench

Round-robin arbiter that shares one toggle switch output (`out`) among N requesters. Each granted request flips `out` once and holds exclusive ownership for a fixed window. A one-cycle cooldown separates grants. It sits in front of the Mealy switch logic, sequences which control source may drive it, and counts toggles for status readout.

---
 rtl/switch_share_arbiter_if.sv | 27 ++
 rtl/switch_share_arbiter.sv | 98 +++++++++
 tb/tb_switch_share_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/switch_share_arbiter_if.sv
// Request/grant bundle between control sources and the shared-switch arbiter.
// The master drives requests; the arbiter (slave) returns grant and status.
interface switch_share_arbiter_if #(
   parameter int N = 4
);
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         busy;
   logic         out;
   logic [7:0]   toggle_count;

   modport master (
      output req,
      input  grant,
      input  busy,
      input  out,
      input  toggle_count
   );

   modport slave (
      input  req,
      output grant,
      output busy,
      output out,
      output toggle_count
   );
endinterface

// File: rtl/switch_share_arbiter.sv
// Round-robin arbiter sharing one toggle switch among N sources.
// Each grant flips the switch once, holds ownership for a bounded window, then cools down.
//
// state | meaning
// IDLE  | no owner; pick a round-robin winner if any request is up
// GRANT | winner owns the switch until hold limit or early release
// COOL  | one dead cycle before the next arbitration
module switch_share_arbiter #(
   parameter int N           = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   switch_share_arbiter_if.slave  bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_COOL  = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  grant_q;
   logic          busy_q;
   logic          out_q;
   logic [7:0]    toggle_count_q;
   logic [3:0]    hold_q;
   logic [PW-1:0] last_winner_q;

   logic [PW-1:0] winner_d;
   logic          found_d;
   int            idx;

   // Search starts one past the previous winner and wraps, so index 0 leads after reset.
   always_comb begin
      winner_d = last_winner_q;
      found_d  = 1'b0;
      idx      = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last_winner_q) + i) % N;
         if (!found_d && bus.req[idx]) begin
            found_d  = 1'b1;
            winner_d = PW'(idx);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q        <= ST_IDLE;
         grant_q        <= '0;
         busy_q         <= 1'b0;
         out_q          <= 1'b0;
         toggle_count_q <= 8'd0;
         hold_q         <= 4'd0;
         last_winner_q  <= PW'(N - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (found_d) begin
                  state_q        <= ST_GRANT;
                  grant_q        <= N'(1) << winner_d;
                  busy_q         <= 1'b1;
                  out_q          <= ~out_q;
                  toggle_count_q <= toggle_count_q + 8'd1;
                  hold_q         <= 4'd1;
                  last_winner_q  <= winner_d;
               end
            end
            ST_GRANT: begin
               if (hold_q == 4'(HOLD_CYCLES) || !bus.req[last_winner_q]) begin
                  state_q <= ST_COOL;
                  grant_q <= '0;
               end else begin
                  hold_q <= hold_q + 4'd1;
               end
            end
            ST_COOL: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;
   assign bus.out          = out_q;
   assign bus.toggle_count = toggle_count_q;

endmodule

// File: tb/tb_switch_share_arbiter.sv
// Bench for switch_share_arbiter: vector table, hand-written corner sequences,
// then randomized requests against a behavioural model.
module tb_switch_share_arbiter;
   localparam int N    = 4;
   localparam int HOLD = 4;

   logic clock_i = 1'b0;
   logic reset_i;

   switch_share_arbiter_if #(.N(N)) bus ();

   switch_share_arbiter #(.N(N), .HOLD_CYCLES(HOLD)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] grant;
      logic       busy;
      logic       out;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // behavioural model state
   int   m_owner;
   int   m_held;
   bit   m_cool;
   int   m_ptr;
   bit   m_out;
   int   m_cnt;

   task automatic step(input logic r_n, input logic [3:0] r);
      reset_i = r_n;
      bus.req = r;
      @(posedge clock_i);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] g, input logic b,
                        input logic o, input logic [7:0] c);
      checks++;
      if (bus.grant !== g || bus.busy !== b || bus.out !== o || bus.toggle_count !== c) begin
         errors++;
         $display("FAIL %s: got grant=%b busy=%b out=%b cnt=%0d, expected grant=%b busy=%b out=%b cnt=%0d",
                  name, bus.grant, bus.busy, bus.out, bus.toggle_count, g, b, o, c);
      end
   endtask

   task automatic add_vec(input logic r_n, input logic [3:0] r, input logic [3:0] g,
                          input logic b, input logic o, input int c);
      vec_t v;
      v.rst_n = r_n; v.req = r; v.grant = g; v.busy = b; v.out = o; v.cnt = 8'(c);
      vecs.push_back(v);
   endtask

   task automatic model_step(input logic r_n, input logic [3:0] r);
      bit found;
      int cand;
      if (!r_n) begin
         m_owner = -1; m_held = 0; m_cool = 0; m_ptr = N - 1; m_out = 0; m_cnt = 0;
      end else if (m_cool) begin
         m_cool = 0;
      end else if (m_owner >= 0) begin
         if (m_held == HOLD || !r[m_owner]) begin
            m_owner = -1;
            m_cool  = 1;
         end else begin
            m_held++;
         end
      end else if (r != 0) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            cand = (m_ptr + k) % N;
            if (!found && r[cand]) begin
               found   = 1;
               m_owner = cand;
            end
         end
         m_ptr  = m_owner;
         m_held = 1;
         m_out  = ~m_out;
         m_cnt  = (m_cnt + 1) % 256;
      end
   endtask

   initial begin
      logic [3:0] r;
      logic       rn;
      int         hold_left;

      reset_i = 1'b0;
      bus.req = '0;

      // reset held with all requests up
      for (int k = 0; k < 3; k++) add_vec(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 0);
      // fairness: 5 full grants with constant requests, order 0,1,2,3,0
      for (int g = 0; g < 5; g++)
         for (int c = 0; c < 6; c++)
            add_vec(1'b1, 4'b1111, (c < 4) ? 4'(1 << (g % 4)) : 4'b0000,
                    c < 5, 1'((g + 1) & 1), g + 1);
      add_vec(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0);
      // single requester on index 2 for 20 cycles
      for (int k = 0; k < 20; k++)
         add_vec(1'b1, 4'b0100, ((k % 6) < 4) ? 4'b0100 : 4'b0000,
                 (k % 6) < 5, 1'(((k / 6) + 1) & 1), (k / 6) + 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst_n, vecs[i].req);
         check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].out, vecs[i].cnt);
      end

      // early release after 2 cycles of ownership
      step(1'b0, 4'b0000);
      step(1'b1, 4'b0010);
      check("early_rise", 4'b0010, 1'b1, 1'b1, 8'd1);
      step(1'b1, 4'b0010);
      check("early_hold", 4'b0010, 1'b1, 1'b1, 8'd1);
      step(1'b1, 4'b0000);
      check("early_drop", 4'b0000, 1'b1, 1'b1, 8'd1);
      step(1'b1, 4'b0000);
      check("early_cool_end", 4'b0000, 1'b0, 1'b1, 8'd1);

      // 256 full grants wrap the counter and restore out
      step(1'b0, 4'b0000);
      for (int k = 0; k < 256 * 6; k++) step(1'b1, 4'b0001);
      check("wrap256", 4'b0000, 1'b0, 1'b0, 8'd0);
      step(1'b1, 4'b1111);
      check("post_wrap_rr", 4'b0010, 1'b1, 1'b1, 8'd1);
      step(1'b0, 4'b1111);
      check("mid_reset", 4'b0000, 1'b0, 1'b0, 8'd0);
      step(1'b1, 4'b1111);
      check("ptr_restored", 4'b0001, 1'b1, 1'b1, 8'd1);

      // randomized requests against the model
      step(1'b0, 4'b0000);
      model_step(1'b0, 4'b0000);
      r = '0;
      hold_left = 0;
      for (int k = 0; k < 1500; k++) begin
         if (hold_left == 0) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            hold_left = $urandom_range(1, 8);
         end
         hold_left--;
         rn = ($urandom_range(0, 149) != 0);
         step(rn, r);
         model_step(rn, r);
         check($sformatf("rand%0d", k),
               (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000,
               (m_owner >= 0) || m_cool, m_out, 8'(m_cnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
